// File: rtl/bcd_tick_counter.sv
// Multi-digit up/down BCD counter stepped by an internal clock-enable prescaler, with 7-segment decode.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0 on Hex.
module bcd_tick_counter #(
   parameter int DIV_COUNT = 50_000_000,
   parameter int DIGITS    = 2,
   parameter int MODULUS   = 100
) (
   input  logic                  Clock,
   input  logic                  Reset_n,
   input  logic                  En,
   input  logic                  Up,
   input  logic                  Clear,
   output logic [4*DIGITS-1:0]   Bcd,
   output logic [7*DIGITS-1:0]   Hex,
   output logic                  Tick,
   output logic                  Wrap
);

   function automatic int pow10(input int n);
      int r;
      r = 1;
      for (int k = 0; k < n; k++) r = r * 10;
      return r;
   endfunction

   function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
      logic [4*DIGITS-1:0] r;
      int t;
      r = '0;
      t = v;
      for (int k = 0; k < DIGITS; k++) begin
         r[4*k +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   if (DIGITS < 1 || DIGITS > 8 || MODULUS < 2 || MODULUS > pow10(DIGITS) || DIV_COUNT < 1) begin : g_param_err
      $error("bcd_tick_counter: illegal DIV_COUNT/DIGITS/MODULUS");
   end

   localparam int                  PW         = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
   localparam logic [PW-1:0]       PRESC_LAST = PW'(DIV_COUNT - 1);
   localparam logic [4*DIGITS-1:0] MAX_BCD    = to_bcd(MODULUS - 1);

   logic [PW-1:0]       presc_q, presc_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;
   logic                tick_q, tick_d;
   logic                wrap_q, wrap_d;
   logic                step;
   logic [4*DIGITS-1:0] inc_bcd, dec_bcd;

   assign step = En && (presc_q == PRESC_LAST);

   // Ripple carry/borrow across digits; the modulus wrap is handled separately below.
   always_comb begin
      logic       carry;
      logic       borrow;
      logic [3:0] dig;
      inc_bcd = '0;
      dec_bcd = '0;
      carry   = 1'b1;
      borrow  = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         dig = bcd_q[4*i +: 4];
         if (!carry)             inc_bcd[4*i +: 4] = dig;
         else if (dig == 4'd9)   inc_bcd[4*i +: 4] = 4'd0;
         else begin
            inc_bcd[4*i +: 4] = dig + 4'd1;
            carry             = 1'b0;
         end
         if (!borrow)            dec_bcd[4*i +: 4] = dig;
         else if (dig == 4'd0)   dec_bcd[4*i +: 4] = 4'd9;
         else begin
            dec_bcd[4*i +: 4] = dig - 4'd1;
            borrow            = 1'b0;
         end
      end
   end

   always_comb begin
      presc_d = presc_q;
      bcd_d   = bcd_q;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      if (Clear) begin
         presc_d = '0;
         bcd_d   = '0;
      end else if (step) begin
         presc_d = '0;
         tick_d  = 1'b1;
         if (Up) begin
            if (bcd_q == MAX_BCD) begin
               bcd_d  = '0;
               wrap_d = 1'b1;
            end else begin
               bcd_d = inc_bcd;
            end
         end else begin
            if (bcd_q == '0) begin
               bcd_d  = MAX_BCD;
               wrap_d = 1'b1;
            end else begin
               bcd_d = dec_bcd;
            end
         end
      end else if (En) begin
         presc_d = presc_q + PW'(1);
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         presc_q <= '0;
         bcd_q   <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         bcd_q   <= bcd_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
      end
   end

   assign Bcd  = bcd_q;
   assign Tick = tick_q;
   assign Wrap = wrap_q;

`ifdef LEADING_ZERO_BLANK_EN
   always_comb begin
      logic zero_above;
      Hex        = '1;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above && (bcd_q[4*i +: 4] == 4'd0);
         if (i != 0 && zero_above) Hex[7*i +: 7] = 7'b1111111;
         else                      Hex[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
      end
   end
`else
   always_comb begin
      Hex = '1;
      for (int i = 0; i < DIGITS; i++) Hex[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
   end
`endif

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench for bcd_tick_counter with DIV_COUNT=4, DIGITS=2, MODULUS=12.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bcd_tick_counter;

   logic        Clock = 1'b0;
   logic        Reset_n, En, Up, Clear;
   logic [7:0]  Bcd;
   logic [13:0] Hex;
   logic        Tick, Wrap;

   int checks   = 0;
   int failures = 0;

   // Count sequences indexed by number of steps taken (mod 12).
   logic [7:0] up_seq [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                               8'h06, 8'h07, 8'h08, 8'h09, 8'h10, 8'h11};
   logic [7:0] dn_seq [12] = '{8'h00, 8'h11, 8'h10, 8'h09, 8'h08, 8'h07,
                               8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] HI_ZERO = 7'h7F;
`else
   localparam logic [6:0] HI_ZERO = 7'h40;
`endif

   bcd_tick_counter #(.DIV_COUNT(4), .DIGITS(2), .MODULUS(12)) dut (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .En      (En),
      .Up      (Up),
      .Clear   (Clear),
      .Bcd     (Bcd),
      .Hex     (Hex),
      .Tick    (Tick),
      .Wrap    (Wrap)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   initial begin
      Reset_n = 1'b0;
      En      = 1'b0;
      Up      = 1'b1;
      Clear   = 1'b0;
      @(negedge Clock);
      Reset_n = 1'b1;
      En      = 1'b1;
      repeat (8) cyc();
      check("pre_reset_bcd", 32'(Bcd), 32'h02);
      check("hex_two", 32'(Hex), {18'd0, HI_ZERO, 7'h24});

      // Asynchronous reset between edges, mid-count
      #2 Reset_n = 1'b0;
      #1;
      check("rst_bcd", 32'(Bcd), 32'h00);
      check("rst_tick", 32'(Tick), 32'd0);
      check("rst_wrap", 32'(Wrap), 32'd0);
`ifdef LEADING_ZERO_BLANK_EN
      check("rst_hex", 32'(Hex), 32'h3FC0);
`else
      check("rst_hex", 32'(Hex), 32'h2040);
`endif
      @(negedge Clock);
      Reset_n = 1'b1;

      // Up run: 60 cycles, tick every 4th, wrap on 11->00
      for (int n = 1; n <= 60; n++) begin
         cyc();
         check("up_tick", 32'(Tick), 32'((n % 4) == 0));
         check("up_bcd", 32'(Bcd), 32'(up_seq[(n / 4) % 12]));
         check("up_wrap", 32'(Wrap), 32'((n % 4) == 0 && ((n / 4) % 12) == 0));
         if (up_seq[(n / 4) % 12] == 8'h09)
            check("hex_nine", 32'(Hex), {18'd0, HI_ZERO, 7'h10});
      end

      // Clear to start the down run from 00 with prescaler at 0
      Clear = 1'b1;
      cyc();
      Clear = 1'b0;
      check("clr_bcd", 32'(Bcd), 32'h00);
      check("clr_tick", 32'(Tick), 32'd0);

      // Down run: first tick wraps to 11, then borrows down to 00
      Up = 1'b0;
      for (int n = 1; n <= 48; n++) begin
         cyc();
         check("dn_tick", 32'(Tick), 32'((n % 4) == 0));
         check("dn_bcd", 32'(Bcd), 32'(dn_seq[(n / 4) % 12]));
         check("dn_wrap", 32'(Wrap), 32'((n % 4) == 0 && ((n / 4) % 12) == 1));
      end

      // Freeze after 2 prescale cycles
      Up = 1'b1;
      repeat (2) cyc();
      En = 1'b0;
      for (int n = 0; n < 10; n++) begin
         cyc();
         check("frz_tick", 32'(Tick), 32'd0);
         check("frz_bcd", 32'(Bcd), 32'h00);
      end
      En = 1'b1;
      cyc();
      check("resume1_tick", 32'(Tick), 32'd0);
      cyc();
      check("resume2_tick", 32'(Tick), 32'd1);
      check("resume2_bcd", 32'(Bcd), 32'h01);

      // Count down to 11, then Clear on the step cycle
      Up = 1'b0;
      repeat (8) cyc();
      check("pre_clr_bcd", 32'(Bcd), 32'h11);
      check("pre_clr_wrap", 32'(Wrap), 32'd1);
      check("hex_eleven", 32'(Hex), 32'h3CF9);
      repeat (3) cyc();
      Clear = 1'b1;
      cyc();
      Clear = 1'b0;
      check("clrstep_bcd", 32'(Bcd), 32'h00);
      check("clrstep_tick", 32'(Tick), 32'd0);
      check("clrstep_wrap", 32'(Wrap), 32'd0);
      repeat (3) cyc();
      check("clrstep_p3_tick", 32'(Tick), 32'd0);
      cyc();
      check("clrstep_p4_tick", 32'(Tick), 32'd1);
      check("clrstep_p4_bcd", 32'(Bcd), 32'h11);

      // Up from 11: 00, 01 .. 05, then check blanking
      Up = 1'b1;
      repeat (24) cyc();
      check("blank_bcd", 32'(Bcd), 32'h05);
      check("blank_hi", 32'(Hex[13:7]), 32'(HI_ZERO));
      check("blank_lo", 32'(Hex[6:0]), 32'h12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
